adc_sample_sequencer: RTL and testbench
=======================================

Name: adc_sample_sequencer

Overview:
- Sits directly downstream of the SIPO conversion controller and its shift register in the acoustics front end.
- Paces conversions by driving that controller's active-low reset: released to run one conversion, asserted to re-arm it.
- Captures each parallel ADC word when data_ready asserts and queues it in a small first-word-fall-through FIFO.
- The FIFO feeds the sample-processing logic through a valid/ready read port.

Parameters:
- DATA_W, 12: ADC sample width in bits.
- DEPTH, 16: FIFO depth in words; must be a power of 2, at least 2.
- SAMPLE_PERIOD, 64: clocks from one conversion start to the next; must be at least 24.
- TIMEOUT, 40: clocks allowed in CONVERT before the conversion is abandoned; must satisfy TIMEOUT < SAMPLE_PERIOD.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  level; 1 = run periodic conversions.
- clear_flags  in  1  single-cycle pulse; clears the overflow and timeout flags.
- data_ready  in  1  from the SIPO controller; high while a completed word is held.
- sample_data  in  DATA_W  parallel word from the SIPO shift register; valid while data_ready = 1.
- conv_rst_b  out  1  active-low reset to the SIPO controller; 0 holds it in its idle state.
- rd_valid  out  1  FIFO not empty.
- rd_data  out  DATA_W  head of FIFO; valid when rd_valid = 1.
- rd_ready  in  1  consumer accepts the head word; pop occurs when rd_valid and rd_ready are both 1.
- fifo_count  out  clog2(DEPTH)+1  number of words currently stored.
- overflow  out  1  sticky; a sample was dropped because the FIFO was full.
- timeout  out  1  sticky; a conversion produced no data_ready within TIMEOUT clocks.

Behaviour:
- Reset values: state = IDLE, conv_rst_b = 0, FIFO empty, rd_valid = 0, rd_data = 0, fifo_count = 0, overflow = 0, timeout = 0, period counter = 0.
- All outputs are registered. rd_data is the registered head entry.
- State machine states:
  - IDLE: conv_rst_b = 0. Go to CONVERT when enable = 1.
  - CONVERT: conv_rst_b = 1. The period counter is cleared to 0 on entry and increments every clock.
    - If data_ready = 1: push sample_data, go to HOLD.
    - Else if period counter = TIMEOUT-1: set timeout, go to HOLD with no push.
  - HOLD: conv_rst_b = 0. The counter keeps incrementing.
    - When counter = SAMPLE_PERIOD-1: go to CONVERT if enable = 1, else IDLE.
- data_ready is sampled as a level. This is safe because conv_rst_b = 0 forces the controller's data_ready low before every CONVERT.
- Exactly one push per CONVERT visit. The push is registered on the same edge as the transition to HOLD.
- Resulting conversion start spacing is exactly SAMPLE_PERIOD clocks while enable stays at 1.
- enable deasserted during CONVERT: the current conversion completes or times out, then HOLD, then IDLE. No conversion is aborted mid-word.
- FIFO write when full and no pop in the same cycle: the word is dropped, overflow is set, and the FIFO contents are unchanged.
- Push and pop in the same cycle:
  - Both take effect and fifo_count is unchanged.
  - This holds when full: the push is accepted and overflow is not set.
  - When empty, rd_valid = 0, so no pop occurs; the push lands and rd_valid = 1 on the next cycle.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. Full is fifo_count = DEPTH; empty is fifo_count = 0.
- clear_flags and a new set event in the same cycle: the set wins and the flag reads 1.
- reset asserted mid-conversion: everything returns to reset values on the next edge, including FIFO contents being discarded and conv_rst_b = 0.

Decomposition:
- Shared package (acoustics_pkg):
  - State encoding constants IDLE, CONVERT, HOLD.
  - Default ADC_DATA_W = 12.
  - A clog2 helper function.
- One natural sub-module: sample_fifo, a parameterised synchronous FWFT FIFO exposing push, pop, data, count and full/empty.
- Sequencing FSM, period counter and sticky flags stay in the top module.

Test Plan:
- Reset, then enable = 1 with a controller model asserting data_ready 18 clocks after conv_rst_b rises, words 0x123, 0x456, … → conv_rst_b rises every 64 clocks; rd_data sequence is 0x123, 0x456, …; fifo_count increments per sample; rd_ready held 0.
- DEPTH = 4, rd_ready = 0, 6 conversions → fifo_count saturates at 4; overflow = 1 after the 5th capture; rd_data still equals the 1st word.
- FIFO full with rd_ready = 1 on the cycle of the 5th capture → fifo_count stays at 4, overflow stays 0, the 5th word appears in order.
- data_ready never asserted → timeout = 1 exactly 40 clocks after CONVERT entry; conv_rst_b = 0 in HOLD; next start 64 clocks after the previous start; no push.
- clear_flags pulse with no concurrent event → overflow = 0 and timeout = 0 next cycle. clear_flags concurrent with an overflow drop → overflow remains 1.
- reset pulsed 10 clocks into CONVERT with 3 words queued → next cycle conv_rst_b = 0, rd_valid = 0, fifo_count = 0, both flags 0, state IDLE.

Source files
------------

// File: rtl/adc_sample_sequencer_pkg.sv
// Shared acoustics front-end definitions: sequencer state encoding, default
// ADC word width and a constant-evaluable ceil(log2) helper.
package acoustics_pkg;

    localparam int ADC_DATA_W = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        HOLD    = 2'd2
    } seq_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/adc_sample_sequencer_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head word, so the
// read data leaves the block straight from a flop rather than the storage mux.
module sample_fifo
    import acoustics_pkg::*;
#(
    parameter int DATA_W = ADC_DATA_W,
    parameter int DEPTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push_i,
    input  logic [DATA_W-1:0]       wdata_i,
    input  logic                    pop_i,
    output logic [DATA_W-1:0]       rdata_o,
    output logic                    valid_o,
    output logic [clog2(DEPTH):0]   count_o,
    output logic                    full_o,
    output logic                    empty_o
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW + 1)'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q, count_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic              valid_q;
    logic              do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign do_pop  = pop_i & ~empty_o;
    // A pop frees a slot on the same edge, so a push into a full FIFO still lands.
    assign do_push = push_i & (~full_o | do_pop);

    assign count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};

    always_comb begin
        head_d = head_q;
        if (do_push && (empty_o || (count_q == ONE_CNT && do_pop))) begin
            head_d = wdata_i;
        end else if (do_pop) begin
            head_d = mem_q[rd_ptr_q + AW'(1)];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            head_q   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            valid_q <= (count_d != '0);
            head_q  <= head_d;
        end
    end

    assign rdata_o = head_q;
    assign valid_o = valid_q;
    assign count_o = count_q;

endmodule

// File: rtl/adc_sample_sequencer.sv
// Paces SIPO ADC conversions through the controller's active-low reset, captures
// each finished word into a FWFT FIFO and keeps sticky overflow/timeout flags.
module adc_sample_sequencer
    import acoustics_pkg::*;
#(
    parameter int DATA_W        = ADC_DATA_W,
    parameter int DEPTH         = 16,
    parameter int SAMPLE_PERIOD = 64,
    parameter int TIMEOUT       = 40
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    clear_flags,
    input  logic                    data_ready,
    input  logic [DATA_W-1:0]       sample_data,
    output logic                    conv_rst_b,
    output logic                    rd_valid,
    output logic [DATA_W-1:0]       rd_data,
    input  logic                    rd_ready,
    output logic [clog2(DEPTH):0]   fifo_count,
    output logic                    overflow,
    output logic                    timeout
);

    localparam int CW = clog2(SAMPLE_PERIOD);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(SAMPLE_PERIOD - 1);

    seq_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          conv_rst_b_q;
    logic          overflow_q, overflow_d;
    logic          timeout_q, timeout_d;
    logic          push, drop, timeout_evt;
    logic          fifo_full, fifo_empty;

    // data_ready is a level: the controller is held in reset before every
    // CONVERT, so the first high level seen here is always a fresh word.
    assign push        = (state_q == CONVERT) & data_ready;
    assign timeout_evt = (state_q == CONVERT) & ~data_ready & (cnt_q == TO_LAST);
    assign drop        = push & fifo_full & ~(rd_ready & ~fifo_empty);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            conv_rst_b_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (enable) begin
                        state_q      <= CONVERT;
                        conv_rst_b_q <= 1'b1;
                    end
                end
                CONVERT: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (data_ready || cnt_q == TO_LAST) begin
                        state_q      <= HOLD;
                        conv_rst_b_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (cnt_q == PER_LAST) begin
                        cnt_q <= '0;
                        if (enable) begin
                            state_q      <= CONVERT;
                            conv_rst_b_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    cnt_q        <= '0;
                    conv_rst_b_q <= 1'b0;
                end
            endcase
        end
    end

    // A set event in the same cycle as clear_flags wins.
    always_comb begin
        overflow_d = (overflow_q & ~clear_flags) | drop;
        timeout_d  = (timeout_q & ~clear_flags) | timeout_evt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
        end
    end

    sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i (sample_data),
        .pop_i   (rd_ready),
        .rdata_o (rd_data),
        .valid_o (rd_valid),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign conv_rst_b = conv_rst_b_q;
    assign overflow   = overflow_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Bench for adc_sample_sequencer: table of directed phases plus a randomized run,
// every cycle compared against a transaction-level model with a SIPO controller stand-in.
module tb_adc_sample_sequencer;

    localparam int DW    = 12;
    localparam int DEPTH = 4;
    localparam int SP    = 64;
    localparam int TO    = 40;
    localparam int CNTW  = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            enable = 1'b0;
    logic            clear_flags = 1'b0;
    logic            data_ready = 1'b0;
    logic [DW-1:0]   sample_data = '0;
    logic            conv_rst_b;
    logic            rd_valid;
    logic [DW-1:0]   rd_data;
    logic            rd_ready = 1'b0;
    logic [CNTW-1:0] fifo_count;
    logic            overflow;
    logic            timeout;

    always #5 clk = ~clk;

    adc_sample_sequencer #(
        .DATA_W        (DW),
        .DEPTH         (DEPTH),
        .SAMPLE_PERIOD (SP),
        .TIMEOUT       (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .clear_flags (clear_flags),
        .data_ready  (data_ready),
        .sample_data (sample_data),
        .conv_rst_b  (conv_rst_b),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_ready    (rd_ready),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .timeout     (timeout)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // SIPO controller stand-in: data_ready rises ctl_delay clocks after conv_rst_b rises.
    int   ctl_cnt = 0;
    int   ctl_delay = 18;
    int   ctl_idx = 0;
    bit   prev_conv = 1'b0;

    function automatic logic [DW-1:0] word_of(input int k);
        return DW'(32'h123 + 32'h333 * k);
    endfunction

    task automatic ctl_update();
        if (conv_rst_b === 1'b1) begin
            ctl_cnt = prev_conv ? ctl_cnt + 1 : 0;
        end else begin
            if (data_ready) ctl_idx++;
            ctl_cnt = 0;
        end
        prev_conv   = (conv_rst_b === 1'b1);
        data_ready  = prev_conv && (ctl_cnt >= ctl_delay);
        sample_data = word_of(ctl_idx);
    endtask

    // Reference model: time since conversion start, one capture-or-timeout per
    // period, and a plain queue for the FIFO.
    logic [DW-1:0] m_q[$];
    bit m_active = 0, m_done = 0, m_ovf = 0, m_to = 0, m_fresh = 1;
    int m_t = 0;

    task automatic model_edge();
        bit pop, push, full_before, set_ovf, set_to;
        if (reset) begin
            m_q.delete();
            m_active = 0; m_done = 0; m_t = 0;
            m_ovf = 0; m_to = 0; m_fresh = 1;
            return;
        end
        pop = rd_ready && (m_q.size() > 0);
        push = 0; set_ovf = 0; set_to = 0;
        full_before = (m_q.size() == DEPTH);
        if (!m_active) begin
            if (enable) begin
                m_active = 1; m_t = 0; m_done = 0;
            end
        end else begin
            if (!m_done) begin
                if (data_ready) begin
                    push = 1; m_done = 1;
                end else if (m_t == TO - 1) begin
                    set_to = 1; m_done = 1;
                end
            end
            if (m_t == SP - 1) begin
                if (enable) begin
                    m_t = 0; m_done = 0;
                end else begin
                    m_active = 0;
                end
            end else begin
                m_t++;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (full_before && !pop) set_ovf = 1;
            else begin
                m_q.push_back(sample_data);
                m_fresh = 0;
            end
        end
        if (clear_flags) begin
            m_ovf = 0; m_to = 0;
        end
        if (set_ovf) m_ovf = 1;
        if (set_to) m_to = 1;
    endtask

    task automatic compare_model();
        chk("conv_rst_b", 32'(conv_rst_b), 32'(m_active && !m_done));
        chk("rd_valid", 32'(rd_valid), 32'(m_q.size() > 0));
        chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("timeout", 32'(timeout), 32'(m_to));
        if (m_q.size() > 0) chk("rd_data", 32'(rd_data), 32'(m_q[0]));
        else if (m_fresh) chk("rd_data_rst", 32'(rd_data), 32'h0);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        ctl_update();
        compare_model();
    endtask

    typedef struct {
        bit            rst, en, rr, clr;
        int            delay;
        int            n;
        bit            conv, valid;
        logic [DW-1:0] data;
        int            count;
        bit            ovf, to;
    } row_t;

    row_t rows[20];

    initial begin
        //          rst en rr clr delay  n   conv vld data    cnt ovf to
        rows[0]  = '{1, 0, 0, 0, 18,    2,   0, 0, 12'h000, 0, 0, 0};
        rows[1]  = '{0, 1, 0, 0, 18,    20,  0, 1, 12'h123, 1, 0, 0};
        rows[2]  = '{0, 1, 0, 0, 18,    64,  0, 1, 12'h123, 2, 0, 0};
        rows[3]  = '{0, 1, 0, 0, 18,    192, 0, 1, 12'h123, 4, 1, 0};
        rows[4]  = '{0, 1, 0, 1, 18,    1,   0, 1, 12'h123, 4, 0, 0};
        rows[5]  = '{0, 1, 0, 0, 18,    62,  1, 1, 12'h123, 4, 0, 0};
        rows[6]  = '{0, 1, 0, 1, 18,    1,   0, 1, 12'h123, 4, 1, 0};
        rows[7]  = '{0, 1, 0, 0, 18,    62,  1, 1, 12'h123, 4, 1, 0};
        rows[8]  = '{0, 1, 0, 1, 18,    1,   1, 1, 12'h123, 4, 0, 0};
        rows[9]  = '{0, 1, 1, 0, 18,    1,   0, 1, 12'h456, 4, 0, 0};
        rows[10] = '{0, 1, 1, 0, 18,    4,   0, 0, 12'h000, 0, 0, 0};
        rows[11] = '{0, 1, 0, 0, 1000,  41,  1, 0, 12'h000, 0, 0, 0};
        rows[12] = '{0, 1, 0, 0, 1000,  39,  1, 0, 12'h000, 0, 0, 0};
        rows[13] = '{0, 1, 0, 0, 1000,  1,   0, 0, 12'h000, 0, 0, 1};
        rows[14] = '{0, 1, 0, 0, 1000,  23,  0, 0, 12'h000, 0, 0, 1};
        rows[15] = '{0, 1, 0, 0, 1000,  1,   1, 0, 12'h000, 0, 0, 1};
        rows[16] = '{0, 1, 0, 0, 18,    19,  0, 1, 12'h788, 1, 0, 1};
        rows[17] = '{0, 1, 0, 0, 18,    128, 0, 1, 12'h788, 3, 0, 1};
        rows[18] = '{0, 1, 0, 0, 18,    55,  1, 1, 12'h788, 3, 0, 1};
        rows[19] = '{1, 1, 0, 0, 18,    1,   0, 0, 12'h000, 0, 0, 0};

        for (int i = 0; i < 20; i++) begin
            reset       = rows[i].rst;
            enable      = rows[i].en;
            rd_ready    = rows[i].rr;
            clear_flags = rows[i].clr;
            ctl_delay   = rows[i].delay;
            repeat (rows[i].n) step();
            chk($sformatf("row%0d_conv", i), 32'(conv_rst_b), 32'(rows[i].conv));
            chk($sformatf("row%0d_valid", i), 32'(rd_valid), 32'(rows[i].valid));
            chk($sformatf("row%0d_count", i), 32'(fifo_count), 32'(rows[i].count));
            chk($sformatf("row%0d_ovf", i), 32'(overflow), 32'(rows[i].ovf));
            chk($sformatf("row%0d_to", i), 32'(timeout), 32'(rows[i].to));
            if (rows[i].valid || rows[i].rst)
                chk($sformatf("row%0d_data", i), 32'(rd_data), 32'(rows[i].data));
        end

        // Randomized run: enable toggles, bursty consumer, clear pulses, rare resets,
        // and per-conversion latencies that sometimes exceed the timeout.
        reset = 1'b0;
        clear_flags = 1'b0;
        enable = 1'b1;
        begin
            int rr_pct;
            rr_pct = 0;
            for (int c = 0; c < 6000; c++) begin
                if (c % 400 == 0) begin
                    case ($urandom_range(0, 3))
                        0: rr_pct = 0;
                        1: rr_pct = 1;
                        2: rr_pct = 3;
                        default: rr_pct = 100;
                    endcase
                end
                if ($urandom_range(0, 299) == 0) enable = ~enable;
                rd_ready    = ($urandom_range(0, 99) < rr_pct);
                clear_flags = ($urandom_range(0, 79) == 0);
                reset       = ($urandom_range(0, 2499) == 0);
                if (!prev_conv) ctl_delay = $urandom_range(0, 45);
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
